// File: rtl/tdc_hit_capture.sv
// tdc_hit_capture: time-to-digital hit capture.
// Coarse count is taken in clk cycles since the last ref. The fine code is the
// popcount of the delay-line thermometer snapshot, saturated at FRAC_MAX.
// Result pipeline: latch (RUN) -> half popcounts (ENC1) -> sum/saturate (ENC2)
// -> output register. start therefore rises 3 edges after the edge that
// samples hit_flag.
module tdc_hit_capture #(
    parameter int TAP_N    = 64,
    parameter int FRAC_MAX = 49,
    parameter int DEAD_CYC = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_ref,
    input  logic             i_hit_flag,
    input  logic [TAP_N-1:0] i_therm,
    output logic [10:0]      o_int_data,
    output logic [10:0]      o_frac_data,
    output logic             o_start,
    output logic             o_timeout,
    output logic             o_lost
);

    localparam int HALF = TAP_N / 2;
    localparam int HW   = $clog2(HALF + 1);
    localparam int DW   = $clog2(DEAD_CYC + 1);
    localparam logic [10:0] CMAX = 11'd2047;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_ENC1, S_ENC2, S_DEAD} state_t;

    state_t              r_state, w_next;
    logic [10:0]         r_coarse;      // count for the current cycle; the ref cycle counts 0
    logic [10:0]         r_hit_coarse;
    logic [TAP_N-1:0]    r_therm;
    logic [HW-1:0]       r_cnt_lo, r_cnt_hi;
    logic [10:0]         r_res_int, r_res_frac;
    logic                r_pend;
    logic [DW-1:0]       r_dead;
    logic                w_take, w_timeout, w_lost, w_coarse_ld;
    logic [HW-1:0]       w_pc_lo, w_pc_hi;
    logic [HW:0]         w_sum;
    logic [10:0]         w_sat;

    function automatic logic [HW-1:0] f_pop(input logic [HALF-1:0] v);
        logic [HW-1:0] c;
        c = '0;
        for (int i = 0; i < HALF; i++) c = c + HW'(v[i]);
        return c;
    endfunction

    // Fine encoder: half popcounts (bubble tolerant) and saturated sum.
    always_comb begin
        w_pc_lo = f_pop(r_therm[HALF-1:0]);
        w_pc_hi = f_pop(r_therm[TAP_N-1:HALF]);
        w_sum   = {1'b0, r_cnt_lo} + {1'b0, r_cnt_hi};
        w_sat   = (int'(w_sum) > FRAC_MAX) ? 11'(FRAC_MAX) : 11'(w_sum);
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and strobe decode; a hit outside RUN is always reported lost.
    always_comb begin
        w_next    = r_state;
        w_take    = 1'b0;
        w_timeout = 1'b0;
        w_lost    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_lost = i_hit_flag;
                if (i_en && i_ref) w_next = S_RUN;
            end
            S_RUN: begin
                if (!i_en) begin
                    w_next = S_IDLE;
                    w_lost = i_hit_flag;
                end else if (i_hit_flag) begin
                    w_next = S_ENC1;
                    w_take = 1'b1;
                end else if (!i_ref && r_coarse == CMAX) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_ENC1: begin
                w_lost = i_hit_flag;
                w_next = S_ENC2;
            end
            S_ENC2: begin
                w_lost = i_hit_flag;
                w_next = i_en ? S_DEAD : S_IDLE;
            end
            S_DEAD: begin
                w_lost = i_hit_flag;
                if (!i_en)                           w_next = S_IDLE;
                else if (r_dead == DW'(DEAD_CYC - 1)) w_next = S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A ref is ignored only in IDLE with en low, or when it coincides with a hit in RUN.
    always_comb begin
        w_coarse_ld = 1'b0;
        if (i_ref) begin
            unique case (r_state)
                S_IDLE:  w_coarse_ld = i_en;
                S_RUN:   w_coarse_ld = !i_hit_flag;
                default: w_coarse_ld = 1'b1;
            endcase
        end
    end

    // Coarse counter: counts in every non-IDLE state, saturates at 2047.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                          r_coarse <= '0;
        else if (w_coarse_ld)                               r_coarse <= 11'd1;
        else if (r_state != S_IDLE && r_coarse != CMAX)     r_coarse <= r_coarse + 11'd1;
    end

    // Dead-time counter, cleared whenever not in DEAD.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                  r_dead <= '0;
        else if (r_state != S_DEAD) r_dead <= '0;
        else                        r_dead <= r_dead + DW'(1);
    end

    // Result pipeline and output strobes; reset drops any in-flight result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hit_coarse <= '0;
            r_therm      <= '0;
            r_cnt_lo     <= '0;
            r_cnt_hi     <= '0;
            r_res_int    <= '0;
            r_res_frac   <= '0;
            r_pend       <= 1'b0;
            o_int_data   <= '0;
            o_frac_data  <= '0;
            o_start      <= 1'b0;
            o_timeout    <= 1'b0;
            o_lost       <= 1'b0;
        end else begin
            if (w_take) begin
                r_hit_coarse <= r_coarse;
                r_therm      <= i_therm;
            end
            if (r_state == S_ENC1) begin
                r_cnt_lo <= w_pc_lo;
                r_cnt_hi <= w_pc_hi;
            end
            r_pend <= (r_state == S_ENC2);
            if (r_state == S_ENC2) begin
                r_res_int  <= r_hit_coarse;
                r_res_frac <= w_sat;
            end
            o_start <= r_pend;
            if (r_pend) begin
                o_int_data  <= r_res_int;
                o_frac_data <= r_res_frac;
            end
            o_timeout <= w_timeout;
            o_lost    <= w_lost;
        end
    end

endmodule

// File: tb/tb_tdc_hit_capture.sv
// Scoreboard bench for tdc_hit_capture: expected results are pushed when a hit
// is driven and popped when start is observed.
module tb_tdc_hit_capture;

    logic        clk = 1'b0, rst = 1'b1;
    logic        en = 1'b0, refs = 1'b0, hit = 1'b0;
    logic [63:0] therm = '0;
    logic [10:0] int_data, frac_data;
    logic        start, tmo, lost;

    tdc_hit_capture #(.TAP_N(64), .FRAC_MAX(49), .DEAD_CYC(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_ref(refs), .i_hit_flag(hit),
        .i_therm(therm), .o_int_data(int_data), .o_frac_data(frac_data),
        .o_start(start), .o_timeout(tmo), .o_lost(lost)
    );

    always #5 clk = ~clk;

    typedef struct { int i; int f; int c; } exp_t;
    exp_t sb[$];
    exp_t e;

    int cyc = 0, errs = 0, checks = 0;
    int n_start = 0, n_lost = 0, n_tmo = 0, lost_cyc = -1, tmo_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) if (!rst) begin
        if (start) begin
            n_start++;
            if (sb.size() == 0) chk("start_unexp", 1, 0);
            else begin
                e = sb.pop_front();
                chk("int_data", 32'(int_data), e.i);
                chk("frac_data", 32'(frac_data), e.f);
                chk("start_lat", cyc, e.c);
            end
        end
        if (lost) begin n_lost++; lost_cyc = cyc; end
        if (tmo)  begin n_tmo++;  tmo_cyc = cyc; end
        if (tmo && (start || lost)) chk("strobe_excl", 1, 0);
    end

    task automatic step(input logic r, input logic h, input logic [63:0] t);
        refs = r; hit = h; therm = t;
        @(negedge clk);
        refs = 1'b0; hit = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, '0);
    endtask

    task automatic push(input int iexp, input logic [63:0] t);
        int pc;
        pc = $countones(t);
        sb.push_back('{i: iexp, f: (pc > 49) ? 49 : pc, c: cyc + 4});
    endtask

    // ref, then hit gap cycles later; optionally score the result.
    task automatic ref_hit(input int gap, input logic [63:0] t, input bit score);
        step(1, 0, '0);
        idle(gap - 1);
        if (score) push(gap, t);
        step(0, 1, t);
    endtask

    initial begin
        int m, l0, s0;
        logic [63:0] t;
        repeat (3) @(negedge clk);
        chk("rst_int", 32'(int_data), 0);
        chk("rst_frac", 32'(frac_data), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_tmo", 32'(tmo), 0);
        chk("rst_lost", 32'(lost), 0);
        rst = 1'b0; en = 1'b1;

        // basic capture: 20 LSB ones, int 5
        ref_hit(5, 64'h0000_0000_000F_FFFF, 1); idle(10);
        // saturation and zero code
        ref_hit(3, '1, 1); idle(10);
        ref_hit(1, '0, 1); idle(10);
        // bubbly snapshots, random gaps
        for (int k = 0; k < 4; k++) begin
            t = {$urandom, $urandom};
            ref_hit(int'($urandom_range(1, 30)), t, 1); idle(10);
        end

        // ref coinciding with hit at coarse 10, then counter keeps running
        step(1, 0, '0); idle(9);
        push(10, 64'hFF); step(1, 1, 64'hFF);
        idle(8);
        push(19, 64'h3); step(0, 1, 64'h3);
        idle(10);

        // second hit two cycles later is lost
        l0 = n_lost;
        ref_hit(5, 64'hFFFF, 1); idle(1);
        m = cyc; step(0, 1, '1);
        idle(10);
        chk("lost_cnt", n_lost - l0, 1);
        chk("lost_cyc", lost_cyc, m + 1);

        // en low in ENC1: result still completes, then IDLE
        ref_hit(4, 64'h7F, 1);
        en = 1'b0; idle(6); en = 1'b1;
        l0 = n_lost; s0 = n_start;
        m = cyc; step(0, 1, '1); idle(8);
        chk("idle_lost", n_lost - l0, 1);
        chk("idle_lost_cyc", lost_cyc, m + 1);
        chk("idle_nostart", n_start - s0, 0);

        // timeout after 2047 cycles without a hit
        s0 = n_start;
        m = cyc; step(1, 0, '0);
        idle(2052);
        chk("tmo_cnt", n_tmo, 1);
        chk("tmo_cyc", tmo_cyc, m + 2048);
        chk("tmo_nostart", n_start - s0, 0);
        l0 = n_lost; m = cyc; step(0, 1, '1); idle(2);
        chk("tmo_idle_lost", n_lost - l0, 1);

        // reset in ENC1 discards the result
        ref_hit(6, 64'hFFF, 0);
        rst = 1'b1; @(negedge clk);
        chk("rst2_int", 32'(int_data), 0);
        chk("rst2_frac", 32'(frac_data), 0);
        chk("rst2_start", 32'(start), 0);
        rst = 1'b0;
        ref_hit(7, 64'h0F0F, 1); idle(10);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
